// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encoding and helpers shared by the ALU arbiter slice
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLT = 4'b0100,
    OP_XOR = 4'b0101
  } alu_op_t;

  // Codes above OP_XOR are reserved and flagged as errors.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester and result-slot signals of the shared ALU
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*DATA_W-1:0]   req_a;
  logic [NUM_REQ*DATA_W-1:0]   req_b;
  logic [NUM_REQ*ALU_OP_W-1:0] req_op;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [DATA_W-1:0]           rsp_result;
  logic                        rsp_zero;
  logic [ID_W-1:0]             rsp_id;
  logic                        rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational ALU (AND/OR/ADD/SUB/SLT/XOR)
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic [DATA_W-1:0]   result,
  output logic                zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU among NUM_REQ requesters
// with a single registered result slot under valid/ready backpressure.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     next_ptr;
  logic                found;
  logic                accept;
  logic                hs;
  int                  idx;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [ALU_OP_W-1:0] op_sel;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  assign accept        = ~bus.rsp_valid | bus.rsp_ready;
  // rst_n gating keeps req_ready low for the whole reset window.
  assign hs            = found & accept & rst_n;
  assign bus.req_ready = hs ? (NUM_REQ'(1) << win_idx) : '0;
  assign next_ptr      = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  assign a_sel  = bus.req_a[win_idx*DATA_W +: DATA_W];
  assign b_sel  = bus.req_b[win_idx*DATA_W +: DATA_W];
  assign op_sel = bus.req_op[win_idx*ALU_OP_W +: ALU_OP_W];

  alu_share_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a          (a_sel),
    .b          (b_sel),
    .alu_control(op_sel),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_err    <= 1'b0;
      rr_ptr         <= '0;
    end else if (hs) begin
      bus.rsp_valid  <= 1'b1;
      bus.rsp_result <= alu_result;
      bus.rsp_zero   <= alu_zero;
      bus.rsp_id     <= win_idx;
      bus.rsp_err    <= ~is_legal_op(op_sel);
      rr_ptr         <= next_ptr;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [1:0]  id;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  rsp_t sb[$];
  rsp_t none = '0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_op[i*4 +: 4]   = op;
    bus.req_a[i*DW +: DW]  = a;
    bus.req_b[i*DW +: DW]  = b;
  endtask

  // One clock: check the grant at the negedge, queue the expected result
  // if a handshake is due, then return just after the next rising edge.
  task automatic cycle(input logic [NR-1:0] exp_rdy, input logic push, input rsp_t e);
    @(negedge clk);
    chk("grant", 32'(bus.req_ready), 32'(exp_rdy));
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result that leaves the slot is matched against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual id=%0d required=no result at %0t", bus.rsp_id, $time);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with every requester asking.
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_zero", 32'(bus.rsp_zero), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four valid continuously: grants 0,1,2,3,0 back to back.
    set_req(0, 4'b0010, 32'd1, 32'd2);
    set_req(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
    set_req(2, 4'b0000, 32'h0000_00FF, 32'h0000_000F);
    set_req(3, 4'b0101, 32'd5, 32'd5);
    cycle(4'b0001, 1'b1, '{res: 32'd3,          zero: 1'b0, id: 2'd0, err: 1'b0});
    cycle(4'b0010, 1'b1, '{res: 32'h0000_00FF,  zero: 1'b0, id: 2'd1, err: 1'b0});
    cycle(4'b0100, 1'b1, '{res: 32'h0000_000F,  zero: 1'b0, id: 2'd2, err: 1'b0});
    cycle(4'b1000, 1'b1, '{res: 32'd0,          zero: 1'b1, id: 2'd3, err: 1'b0});
    cycle(4'b0001, 1'b1, '{res: 32'd3,          zero: 1'b0, id: 2'd0, err: 1'b0});
    bus.req_valid = '0;
    cycle(4'b0000, 1'b0, none);

    // Single requester ADD 10,5.
    set_req(0, 4'b0010, 32'd10, 32'd5);
    cycle(4'b0001, 1'b1, '{res: 32'd15, zero: 1'b0, id: 2'd0, err: 1'b0});
    bus.req_valid = '0;
    cycle(4'b0000, 1'b0, none);

    // Backpressure: SUB 20,18 from req1 held three cycles, then req2 granted.
    set_req(1, 4'b0011, 32'd20, 32'd18);
    cycle(4'b0010, 1'b1, '{res: 32'd2, zero: 1'b0, id: 2'd1, err: 1'b0});
    bus.req_valid = '0;
    set_req(2, 4'b0010, 32'd7, 32'd8);
    bus.rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp_result", bus.rsp_result, 32'd2);
      chk("bp_rsp_id", 32'(bus.rsp_id), 1);
      cycle(4'b0000, 1'b0, none);
    end
    bus.rsp_ready = 1'b1;
    cycle(4'b0100, 1'b1, '{res: 32'd15, zero: 1'b0, id: 2'd2, err: 1'b0});
    bus.req_valid = '0;
    cycle(4'b0000, 1'b0, none);

    // Arithmetic edges, back to back from req0.
    set_req(0, 4'b0011, 32'd5, 32'd5);
    cycle(4'b0001, 1'b1, '{res: 32'd0, zero: 1'b1, id: 2'd0, err: 1'b0});
    set_req(0, 4'b0100, 32'hFFFF_FFFF, 32'd1);
    cycle(4'b0001, 1'b1, '{res: 32'd1, zero: 1'b0, id: 2'd0, err: 1'b0});
    set_req(0, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    cycle(4'b0001, 1'b1, '{res: 32'd0, zero: 1'b1, id: 2'd0, err: 1'b0});
    set_req(0, 4'b0101, 32'hFF00_FF00, 32'h00FF_00FF);
    cycle(4'b0001, 1'b1, '{res: 32'hFFFF_FFFF, zero: 1'b0, id: 2'd0, err: 1'b0});
    bus.req_valid = '0;
    cycle(4'b0000, 1'b0, none);

    // Illegal opcode then a legal one from req3.
    set_req(3, 4'b1010, 32'd123, 32'd45);
    cycle(4'b1000, 1'b1, '{res: 32'd0, zero: 1'b1, id: 2'd3, err: 1'b1});
    set_req(3, 4'b0010, 32'd1, 32'd1);
    cycle(4'b1000, 1'b1, '{res: 32'd2, zero: 1'b0, id: 2'd3, err: 1'b0});
    bus.req_valid = '0;
    cycle(4'b0000, 1'b0, none);

    // Reset mid-flight while a result is held; rr_ptr would otherwise favour req2.
    set_req(1, 4'b0011, 32'd20, 32'd18);
    cycle(4'b0010, 1'b1, '{res: 32'd2, zero: 1'b0, id: 2'd1, err: 1'b0});
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    set_req(0, 4'b0010, 32'd3, 32'd4);
    set_req(2, 4'b0000, 32'h0000_0F0F, 32'h0000_00FF);
    cycle(4'b0000, 1'b0, none);
    chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 0);
    sb.delete();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    cycle(4'b0001, 1'b1, '{res: 32'd7, zero: 1'b0, id: 2'd0, err: 1'b0});
    bus.req_valid[0] = 1'b0;
    cycle(4'b0100, 1'b1, '{res: 32'h0000_000F, zero: 1'b0, id: 2'd2, err: 1'b0});
    bus.req_valid = '0;
    cycle(4'b0000, 1'b0, none);
    cycle(4'b0000, 1'b0, none);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
